// File: rtl/serie_rx32.sv
// serie_rx32 - oversampling serial receiver for the 32-bit shift-out stage.
//
// Detects a start bit (0) after idle-high and assembles DATA_W bits sent LSB-first.
// It checks the stop bit (1) and hands the word out over a valid/ready handshake.
// Framing errors and overruns are flagged as one-cycle pulses.
//
// Optional build macro: RX_MAJORITY_EN
//   When defined, every sample point takes a 2-of-3 vote of rx_s over the
//   nominal point +/-1 cycle. The decision moves one cycle later.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low
//   rx_in       serial line, asynchronous, idle high
//   dout        received word, stable while dout_valid=1
//   dout_valid  word available, held until accepted
//   dout_ready  consumer accept (dout_valid & dout_ready)
//   busy        receiver not in IDLE
//   frame_err   one-cycle pulse, stop bit sampled 0
//   overrun     one-cycle pulse, new word dropped because the old one is unaccepted
module serie_rx32 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_W + 1);
`ifdef RX_MAJORITY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  // With voting the decision lands one cycle after the nominal point.
  // Only the start-bit point needs the shift. Later points are relative to it.
  localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT/2 - 1 + DLY);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] NBIT_LAST = NW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t            state, state_nx;
  logic              sync1, rx_s, smp;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [NW-1:0]     nbit, nbit_nx;
  logic [DATA_W-1:0] shreg;
  logic              shift_en, deliver, ovr_hit, ferr_hit;

  // Two-flop synchronizer. It resets to the idle level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

`ifdef RX_MAJORITY_EN
  logic rx_d1, rx_d2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end
  assign smp = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign smp = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    nbit_nx  = nbit;
    shift_en = 1'b0;
    deliver  = 1'b0;
    ovr_hit  = 1'b0;
    ferr_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == CNT_MID) begin
          if (smp) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            cnt_nx   = '0;
            nbit_nx  = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_en = 1'b1;
          cnt_nx   = '0;
          nbit_nx  = nbit + 1'b1;
          if (nbit == NBIT_LAST) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        // The stop decision is mid-bit, so IDLE is back half a bit early.
        // This early return catches back-to-back start bits.
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (smp) begin
            state_nx = IDLE;
            if (!dout_valid || dout_ready) deliver = 1'b1;
            else                           ovr_hit = 1'b1;
          end else begin
            state_nx = WAIT_IDLE;
            ferr_hit = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) parks here instead of spawning frames.
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      nbit       <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      nbit      <= nbit_nx;
      frame_err <= ferr_hit;
      overrun   <= ovr_hit;
      if (shift_en) shreg <= {smp, shreg[DATA_W-1:1]};
      // A new delivery wins over a same-cycle accept, so valid stays high.
      if (deliver) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serie_rx32.sv
// tb_serie_rx32 - directed self-checking bench for serie_rx32 (CLKS_PER_BIT=16).
// Inputs change on the falling edge. A negedge monitor counts output pulses.
module tb_serie_rx32;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_in = 1'b1;
  logic        dout_ready = 1'b1;
  logic [31:0] dout;
  logic        dout_valid, busy, frame_err, overrun;

  int errors = 0;
  int checks = 0;
  int vld_cyc = 0;
  int ferr_cyc = 0;
  int ovr_cyc = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  serie_rx32 #(.CLKS_PER_BIT(CPB), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (dout_valid) begin
      vld_cyc = vld_cyc + 1;
      got.push_back(dout);
    end
    if (frame_err) ferr_cyc = ferr_cyc + 1;
    if (overrun)   ovr_cyc  = ovr_cyc + 1;
  end

  task automatic clr_mon();
    vld_cyc = 0; ferr_cyc = 0; ovr_cyc = 0;
    got.delete();
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic stop, input int lead);
    repeat (lead) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 32; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 32'h0)      begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    reset = 1'b1;
    send_bit(1'b1);
  endtask

  task automatic test_basic();
    clr_mon();
    send_frame(32'hA5C30F81, 1'b1, 1);
    send_bit(1'b1);
    checks++; if (dout !== 32'hA5C30F81) begin errors++; $display("FAIL basic_dout: got %h want a5c30f81", dout); end
    checks++; if (vld_cyc !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cyc); end
    checks++; if (ferr_cyc !== 0) begin errors++; $display("FAIL basic_ferr: got %0d want 0", ferr_cyc); end
    checks++; if (ovr_cyc !== 0)  begin errors++; $display("FAIL basic_ovr: got %0d want 0", ovr_cyc); end
  endtask

  task automatic test_false_start();
    clr_mon();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fstart_busy_hi: got %b want 1", busy); end
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fstart_busy_lo: got %b want 0", busy); end
    send_bit(1'b1);
    checks++; if (vld_cyc !== 0) begin errors++; $display("FAIL fstart_valid: got %0d want 0", vld_cyc); end
  endtask

  task automatic test_frame_err();
    clr_mon();
    send_frame(32'h0000FFFF, 1'b0, 1);
    checks++; if (ferr_cyc !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cyc); end
    checks++; if (vld_cyc !== 0)  begin errors++; $display("FAIL ferr_valid: got %0d want 0", vld_cyc); end
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b want 1", busy); end
    send_frame(32'h12345678, 1'b1, 1);
    send_bit(1'b1);
    checks++; if (dout !== 32'h12345678) begin errors++; $display("FAIL after_break_dout: got %h want 12345678", dout); end
    checks++; if (vld_cyc !== 1)  begin errors++; $display("FAIL after_break_valid: got %0d want 1", vld_cyc); end
    checks++; if (ferr_cyc !== 1) begin errors++; $display("FAIL after_break_ferr: got %0d want 1", ferr_cyc); end
  endtask

  task automatic test_overrun();
    clr_mon();
    dout_ready = 1'b0;
    send_frame(32'h11111111, 1'b1, 1);
    send_frame(32'h22222222, 1'b1, 1);
    send_bit(1'b1);
    checks++; if (dout !== 32'h11111111) begin errors++; $display("FAIL ovr_dout: got %h want 11111111", dout); end
    checks++; if (dout_valid !== 1'b1)   begin errors++; $display("FAIL ovr_valid_held: got %b want 1", dout_valid); end
    checks++; if (ovr_cyc !== 1)         begin errors++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cyc); end
    dout_ready = 1'b1;
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0)   begin errors++; $display("FAIL ovr_accept_clear: got %b want 0", dout_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    clr_mon();
    send_frame(32'h13579BDF, 1'b1, 1);
    send_frame(32'h2468ACE0, 1'b1, 0);
    send_bit(1'b1);
    w0 = (got.size() > 0) ? got[0] : 32'hxxxxxxxx;
    w1 = (got.size() > 1) ? got[1] : 32'hxxxxxxxx;
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got.size()); end
    checks++; if (w0 !== 32'h13579BDF) begin errors++; $display("FAIL b2b_word0: got %h want 13579bdf", w0); end
    checks++; if (w1 !== 32'h2468ACE0) begin errors++; $display("FAIL b2b_word1: got %h want 2468ace0", w1); end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    // Bits 0..9 are 0 and 10..31 are 1 (0xFFFFFC00), so the tail after reset looks like idle.
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (dout !== 32'h0)      begin errors++; $display("FAIL mid_rst_dout: got %h want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", dout_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL mid_rst_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL mid_rst_ovr: got %b want 0", overrun); end
    repeat (CPB - 5) @(negedge clk);
    for (int i = 0; i < 22; i++) send_bit(1'b1);
    checks++; if (vld_cyc !== 0)  begin errors++; $display("FAIL mid_tail_valid: got %0d want 0", vld_cyc); end
    checks++; if (ferr_cyc !== 0) begin errors++; $display("FAIL mid_tail_ferr: got %0d want 0", ferr_cyc); end
    send_frame(32'hDEADBEEF, 1'b1, 1);
    send_bit(1'b1);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_next_dout: got %h want deadbeef", dout); end
    checks++; if (vld_cyc !== 1) begin errors++; $display("FAIL mid_next_valid: got %0d want 1", vld_cyc); end
  endtask

  task automatic test_glitch();
    logic [31:0] exp;
`ifdef RX_MAJORITY_EN
    exp = 32'h00000000;
`else
    exp = 32'h00000020;
`endif
    clr_mon();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        // One high cycle exactly at the single-sample point of bit 5.
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        send_bit(1'b0);
      end
    end
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (dout !== exp)  begin errors++; $display("FAIL glitch_dout: got %h want %h", dout, exp); end
    checks++; if (vld_cyc !== 1) begin errors++; $display("FAIL glitch_valid: got %0d want 1", vld_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serie_rx32.md
Name: serie_rx32

Overview:
- Downstream serial receiver for the 32-bit shift-out transmitter stage of the USB protocol path.
- Oversamples the single-wire line and detects the start bit (0) after idle-high.
- Assembles 32 data bits sent LSB-first, checks the stop bit (1), and hands the word to the consumer over a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535, even values only.
- DATA_W, 32, data bits per frame; must match the transmitter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset: synchronous, active-low.
- rx_in  input  1  serial line, asynchronous to clk, idle high.
- dout  output  DATA_W  received word; stable while dout_valid=1.
- dout_valid  output  1  word available; held until accepted.
- dout_ready  input  1  consumer accepts the word on a cycle where dout_valid=1 and dout_ready=1.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: new word completed while the previous one was still unaccepted.

Behaviour:
- Reset (reset=0 at posedge clk):
  - state=IDLE; all counters=0.
  - dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
  - Synchronizer flops set to 1.
  - Reset has priority over every event, including mid-frame; any partial word is discarded.
- Input path:
  - rx_in passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
  - rx_in to rx_s latency is 2 cycles.
- Bit timer: cycle counter cnt, width clog2(CLKS_PER_BIT); bit counter nbit, width clog2(DATA_W+1).
- IDLE:
  - rx_s=0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt=CLKS_PER_BIT/2-1 (mid start bit), sample rx_s:
    - rx_s=1: false start, return to IDLE with no output.
    - rx_s=0: DATA, cnt=0, nbit=0.
- DATA:
  - At cnt=CLKS_PER_BIT-1, sample: shreg <= {sample, shreg[DATA_W-1:1]}, so the LSB-first stream lands in order; cnt=0; nbit++.
  - When nbit reaches DATA_W -> STOP.
- STOP:
  - At cnt=CLKS_PER_BIT-1, sample the stop bit.
  - Sample=1, dout_valid=0 or dout_ready=1 in that cycle: dout<=shreg, dout_valid<=1 on the next cycle (1-cycle latency from the stop sample); go to IDLE.
  - Sample=1, dout_valid=1 and dout_ready=0: dout keeps the old word, the new word is dropped, overrun pulses 1 cycle; go to IDLE.
  - Sample=0: frame_err pulses 1 cycle, word discarded, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rx_s=1, then IDLE.
  - A held-low line (break) therefore never produces phantom frames.
- Handshake:
  - dout_valid clears on the cycle after acceptance.
  - If acceptance and a new delivery coincide, the new word loads and dout_valid stays 1 with no overrun.
- Back-to-back frames:
  - A start bit immediately after the stop sample is detected, because IDLE is re-entered half a bit early.
  - Frames with zero extra idle are received without loss.
- Leading idle '1' bit emitted by the transmitter before the start bit is ignored as line idle.

Optional Feature:
- Macro RX_MAJORITY_EN.
- Defined:
  - Every sample point (start, data, stop) uses a 2-of-3 majority of rx_s at cnt-1, cnt, cnt+1 around the nominal point.
  - The decision is taken at nominal+1 cycle, so all internal timing shifts by 1 cycle; dout_valid latency is unchanged relative to the decision.
  - A single-cycle glitch at a sample point is rejected.
- Undefined: single sample at the nominal point, as described above.

Test Plan:
- CLKS_PER_BIT=16. Send idle 1, start 0, data 0xA5C3_0F81 LSB-first, stop 1; dout_ready=1 -> dout=0xA5C30F81, dout_valid high 1 cycle, frame_err=0, overrun=0.
- Line low 3 cycles, then high -> false start, no dout_valid, busy returns 0 within 8 cycles.
- Frame 0x0000_FFFF with stop bit 0 -> frame_err 1-cycle pulse, no dout_valid. Line held low 100 cycles, then high, then a valid frame 0x12345678 -> dout=0x12345678.
- dout_ready=0; two consecutive frames 0x11111111 then 0x22222222 -> dout stays 0x11111111, overrun pulses once at the second stop. Then dout_ready=1 -> dout_valid clears next cycle.
- reset=0 for 1 cycle at data bit 10 of a frame -> all outputs 0. The remainder of the interrupted frame produces no dout_valid and no frame_err. The next full frame 0xDEADBEEF is received correctly.
- With RX_MAJORITY_EN: 1-cycle high glitch at the center of a 0 data bit of frame 0x00000000 -> dout=0x00000000. Without the macro, the same stimulus gives the corrupted bit set.
